// File: rtl/rf_adc_capture.sv
// rtl/rf_adc_capture.sv - ADC live monitor and triggered snapshot capture with AXI-stream readout (option: RF_CAPTURE_TIMESTAMP_EN)
module rf_adc_capture #(
    parameter int NUM_CH    = 8,
    parameter int NUM_LINES = 8,
    parameter int SAMPLE_W  = 16,
    parameter int DEPTH     = 1024,
    parameter int SEL_W     = $clog2(NUM_CH)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_CH-1:0]                    s_axis_tvalid,
    input  logic [NUM_CH*NUM_LINES*SAMPLE_W-1:0] s_axis_tdata,
    output logic [NUM_CH-1:0]                    s_axis_tready,
    input  logic [SEL_W-1:0]                     ch_select,
    output logic [NUM_LINES*SAMPLE_W-1:0]        mon_data,
    input  logic                                 arm,
    input  logic                                 force_trig,
    input  logic                                 trig_en,
    input  logic [SAMPLE_W-1:0]                  trig_level,
    output logic                                 capture_busy,
    output logic                                 capture_done,
    output logic                                 m_axis_tvalid,
    output logic [NUM_LINES*SAMPLE_W-1:0]        m_axis_tdata,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready
`ifdef RF_CAPTURE_TIMESTAMP_EN
    ,
    output logic [31:0]                          trig_timestamp
`endif
);

    localparam int WORD = NUM_LINES * SAMPLE_W;
    localparam int AW   = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_READOUT
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [WORD-1:0]     ch_data [NUM_CH];
    logic [SEL_W-1:0]    sel_ch;
    logic [SEL_W-1:0]    cap_ch;
    logic                cap_valid;
    logic [WORD-1:0]     cap_word;
    logic [SAMPLE_W-1:0] cap_line0;
    logic [SAMPLE_W-1:0] prev_line0;
    logic                rising;
    logic                arm_acc;
    logic                trig_beat;
    logic                cap_wr;
    logic                last_wr;
    logic [AW-1:0]       wr_addr;
    logic [AW:0]         rd_cnt;
    logic                rd_en;
    logic                last_hs;
    logic [WORD-1:0]     mem [DEPTH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_data[c] = s_axis_tdata[c*WORD +: WORD];
    end

    // Out-of-range channel selects fall back to channel 0
    always_comb begin
        sel_ch = '0;
        if ({1'b0, ch_select} < (SEL_W+1)'(NUM_CH)) begin
            sel_ch = ch_select;
        end
    end

    assign cap_valid = s_axis_tvalid[cap_ch] & s_axis_tready[cap_ch];
    assign cap_word  = ch_data[cap_ch];
    assign cap_line0 = cap_word[SAMPLE_W-1:0];
    assign rising    = ($signed(cap_line0) > $signed(trig_level)) &&
                       ($signed(prev_line0) <= $signed(trig_level));
    assign arm_acc   = (state == S_IDLE) && arm;
    assign trig_beat = (state == S_ARMED) && cap_valid && (force_trig || (trig_en && rising));
    assign cap_wr    = trig_beat || ((state == S_CAPTURE) && cap_valid);
    assign last_wr   = (state == S_CAPTURE) && cap_valid && (wr_addr == AW'(DEPTH - 1));
    assign rd_en     = (state == S_READOUT) && !rd_cnt[AW] && (!m_axis_tvalid || m_axis_tready);
    assign last_hs   = (state == S_READOUT) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and busy flag
    always_comb begin
        state_nxt    = state;
        capture_busy = 1'b0;
        case (state)
            S_IDLE:    if (arm) state_nxt = S_ARMED;
            S_ARMED: begin
                capture_busy = 1'b1;
                if (trig_beat) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                capture_busy = 1'b1;
                if (last_wr) state_nxt = S_READOUT;
            end
            S_READOUT: if (last_hs) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Input ready and registered live monitor of the selected channel
    always_ff @(posedge clock) begin
        if (reset) begin
            s_axis_tready <= '0;
            mon_data      <= '0;
        end else begin
            s_axis_tready <= '1;
            mon_data      <= ch_data[sel_ch];
        end
    end

    // Arm bookkeeping: capture channel, crossing history and done flag
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_ch       <= '0;
            prev_line0   <= {1'b1, {(SAMPLE_W-1){1'b0}}};
            capture_done <= 1'b0;
        end else begin
            if (arm_acc) begin
                cap_ch       <= sel_ch;
                prev_line0   <= {1'b1, {(SAMPLE_W-1){1'b0}}};
                capture_done <= 1'b0;
            end else if ((state == S_ARMED) && cap_valid) begin
                prev_line0 <= cap_line0;
            end
            if (last_hs) begin
                capture_done <= 1'b1;
            end
        end
    end

    // Write address; the trigger beat lands at 0 and the last write wraps it back to 0
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_addr <= '0;
        end else if (arm_acc) begin
            wr_addr <= '0;
        end else if (cap_wr) begin
            wr_addr <= wr_addr + AW'(1);
        end
    end

    // Capture buffer write port; contents are never cleared
    always_ff @(posedge clock) begin
        if (cap_wr) begin
            mem[wr_addr] <= cap_word;
        end
    end

    // Registered read doubles as the output stage; a new read is issued whenever the stage is free or draining
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_cnt        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (rd_en) begin
                m_axis_tdata  <= mem[rd_cnt[AW-1:0]];
                m_axis_tlast  <= (rd_cnt[AW-1:0] == AW'(DEPTH - 1));
                m_axis_tvalid <= 1'b1;
                rd_cnt        <= rd_cnt + (AW+1)'(1);
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
            if (state != S_READOUT) begin
                rd_cnt <= '0;
            end
        end
    end

`ifdef RF_CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    // Free-running count of capture-channel beats, snapshotted on the trigger beat
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt         <= '0;
            trig_timestamp <= '0;
        end else begin
            if (cap_valid) begin
                ts_cnt <= ts_cnt + 32'd1;
            end
            if (trig_beat) begin
                trig_timestamp <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_adc_capture.sv
// tb/tb_rf_adc_capture.sv - randomized scoreboard bench for rf_adc_capture
module tb_rf_adc_capture;

    localparam int NUM_CH    = 6;
    localparam int NUM_LINES = 8;
    localparam int SAMPLE_W  = 16;
    localparam int DEPTH     = 64;
    localparam int SEL_W     = 3;
    localparam int WORD      = NUM_LINES * SAMPLE_W;

    typedef struct {
        logic [WORD-1:0] data;
        logic            last;
    } beat_t;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_CH-1:0]         s_axis_tvalid;
    logic [NUM_CH*WORD-1:0]    s_axis_tdata;
    logic [NUM_CH-1:0]         s_axis_tready;
    logic [SEL_W-1:0]          ch_select;
    logic [WORD-1:0]           mon_data;
    logic                      arm;
    logic                      force_trig;
    logic                      trig_en;
    logic [SAMPLE_W-1:0]       trig_level;
    logic                      capture_busy;
    logic                      capture_done;
    logic                      m_axis_tvalid;
    logic [WORD-1:0]           m_axis_tdata;
    logic                      m_axis_tlast;
    logic                      m_axis_tready;
`ifdef RF_CAPTURE_TIMESTAMP_EN
    logic [31:0]               trig_timestamp;
`endif

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    rd_mode = 0;
    int    exp_first_cyc = -1;
    beat_t exp_q[$];

    rf_adc_capture #(
        .NUM_CH(NUM_CH), .NUM_LINES(NUM_LINES), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .SEL_W(SEL_W)
    ) dut (
        .clock(clock), .reset(reset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
        .ch_select(ch_select), .mon_data(mon_data),
        .arm(arm), .force_trig(force_trig), .trig_en(trig_en), .trig_level(trig_level),
        .capture_busy(capture_busy), .capture_done(capture_done),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
`ifdef RF_CAPTURE_TIMESTAMP_EN
        , .trig_timestamp(trig_timestamp)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WORD-1:0] rand_word();
        logic [WORD-1:0] w;
        for (int k = 0; k < WORD / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic drive_channels(input int ch, input bit v, input logic [WORD-1:0] w);
        for (int c = 0; c < NUM_CH; c++) begin
            s_axis_tdata[c*WORD +: WORD] = rand_word();
            s_axis_tvalid[c] = 1'($urandom_range(1));
        end
        s_axis_tdata[ch*WORD +: WORD] = w;
        s_axis_tvalid[ch] = v;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_tready"}, WORD'(s_axis_tready), '0);
        chk({tag, "_mon_data"}, mon_data, '0);
        chk({tag, "_busy"}, WORD'(capture_busy), '0);
        chk({tag, "_done"}, WORD'(capture_done), '0);
        chk({tag, "_m_tvalid"}, WORD'(m_axis_tvalid), '0);
        chk({tag, "_m_tdata"}, m_axis_tdata, '0);
        chk({tag, "_m_tlast"}, WORD'(m_axis_tlast), '0);
    endtask

    // kind: 0 ramp forced on first beat, 1 level 50/100/101 prefix, 2 random force,
    // 3 random level crossing, 4 forced on the 37th beat. abort_at>=0 resets after that capture address.
    task automatic run_capture(input int kind, input int ch, input logic ten, input logic [15:0] lvl,
                               input int rmode, input int abort_at);
        logic [WORD-1:0]     w_q[$];
        bit                  v_q[$];
        bit                  f_q[$];
        logic [WORD-1:0]     w;
        logic signed [15:0]  prev, l0, slvl;
        bit                  v, f;
        int                  trig, cnt, last_i, i, need;
        beat_t               e;

        slvl = lvl;
        prev = 16'sh8000;
        trig = -1; cnt = 0; last_i = -1; i = 0;
        need = (abort_at >= 0) ? abort_at + 1 : DEPTH;
        while (cnt < need && i < 4000) begin
            w = rand_word();
            f = 1'b0;
            case (kind)
                0: begin v = 1'b1; l0 = 16'(i); f = (i == 0); end
                1: begin
                    v = (i < 3) ? 1'b1 : ($urandom_range(3) != 0);
                    l0 = (i == 0) ? 16'sd50 : (i == 1) ? 16'sd100 : (i == 2) ? 16'sd101 : 16'($urandom);
                end
                2: begin v = ($urandom_range(3) != 0); l0 = 16'($urandom); f = ($urandom_range(9) == 0); end
                4: begin v = 1'b1; l0 = 16'($urandom); f = (i == 36); end
                default: begin v = ($urandom_range(3) != 0); l0 = 16'(int'($urandom_range(8000)) - 4000); end
            endcase
            w[SAMPLE_W-1:0] = l0;
            if (v) begin
                if (trig < 0) begin
                    if (f || (ten && (l0 > slvl) && (prev <= slvl))) trig = i;
                    prev = l0;
                end
                if (trig >= 0) begin
                    if (abort_at < 0) begin
                        e.data = w;
                        e.last = (cnt == DEPTH - 1);
                        exp_q.push_back(e);
                    end
                    cnt++;
                    last_i = i;
                end
            end
            w_q.push_back(w); v_q.push_back(v); f_q.push_back(f);
            i++;
        end

        rd_mode = rmode;
        @(negedge clock);
        ch_select = SEL_W'(ch); arm = 1'b1; trig_en = ten; trig_level = lvl;
        force_trig = 1'b0; s_axis_tvalid = '0;
        @(negedge clock);
        arm = 1'b0;
        for (int k = 0; k < w_q.size(); k++) begin
            drive_channels(ch, v_q[k], w_q[k]);
            force_trig = f_q[k];
            arm = ($urandom_range(7) == 0);
            ch_select = SEL_W'($urandom_range(7));
            if (k == last_i && abort_at < 0) exp_first_cyc = cyc + 2;
            @(negedge clock);
        end
        force_trig = 1'b0; arm = 1'b0; s_axis_tvalid = '0;

        if (abort_at >= 0) begin
            reset = 1'b1;
            @(negedge clock);
            @(negedge clock);
            check_reset_vals("abort_reset");
            reset = 1'b0;
            @(negedge clock);
            chk("abort_tready_after", WORD'(s_axis_tready), WORD'({NUM_CH{1'b1}}));
            return;
        end

        for (int t = 0; t < 4000 && !capture_done; t++) begin
            if (rmode == 1 && $urandom_range(3) == 0) begin
                arm = 1'b1;
                @(negedge clock);
                arm = 1'b0;
                chk("arm_in_readout_busy", WORD'(capture_busy), '0);
            end else begin
                @(negedge clock);
            end
        end
        chk("capture_done", WORD'(capture_done), WORD'(1));
        chk("readout_remaining", WORD'(exp_q.size()), '0);
        @(negedge clock);
        chk("post_done_busy", WORD'(capture_busy), '0);
        chk("post_done_tvalid", WORD'(m_axis_tvalid), '0);
        chk("post_done_sticky", WORD'(capture_done), WORD'(1));
    endtask

    // Readout monitor: drives tready, pops the scoreboard on every handshake
    initial begin
        bit              in_ro, held;
        logic [WORD-1:0] hd;
        logic            hl;
        int              pidx;
        beat_t           e;
        in_ro = 0; held = 0; pidx = 0; hd = '0; hl = 1'b0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clock);
            case (rd_mode)
                0: m_axis_tready = 1'b1;
                1: begin m_axis_tready = (pidx % 4 == 0) || (pidx % 4 == 3); pidx++; end
                default: m_axis_tready = 1'($urandom_range(1));
            endcase
            if (reset) begin
                in_ro = 0; held = 0;
            end else begin
                if (held) begin
                    chk("stall_hold_tvalid", WORD'(m_axis_tvalid), WORD'(1));
                    chk("stall_hold_tdata", m_axis_tdata, hd);
                    chk("stall_hold_tlast", WORD'(m_axis_tlast), WORD'(hl));
                end
                held = 0;
                if (m_axis_tvalid && !in_ro) begin
                    in_ro = 1;
                    if (exp_first_cyc >= 0) chk("first_valid_latency", WORD'(cyc), WORD'(exp_first_cyc));
                    exp_first_cyc = -1;
                end else if (!m_axis_tvalid && in_ro) begin
                    chk("readout_bubble", WORD'(m_axis_tvalid), WORD'(1));
                end
                if (m_axis_tvalid) begin
                    if (m_axis_tready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_beat", WORD'(exp_q.size()), WORD'(1));
                        end else begin
                            e = exp_q.pop_front();
                            chk("readout_data", m_axis_tdata, e.data);
                            chk("readout_last", WORD'(m_axis_tlast), WORD'(e.last));
                        end
                        if (m_axis_tlast) in_ro = 0;
                    end else begin
                        held = 1; hd = m_axis_tdata; hl = m_axis_tlast;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        fails++; tests++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [WORD-1:0] expw;
        int              sel;
        reset = 1'b1;
        s_axis_tvalid = '0; s_axis_tdata = '0; ch_select = '0;
        arm = 1'b0; force_trig = 1'b0; trig_en = 1'b0; trig_level = '0;
        repeat (3) @(negedge clock);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clock);
        chk("tready_after_reset", WORD'(s_axis_tready), WORD'({NUM_CH{1'b1}}));

        for (int k = 0; k < 12; k++) begin
            sel = (k == 0) ? 3 : int'($urandom_range(7));
            drive_channels(0, 1'($urandom_range(1)), rand_word());
            if (k == 0) s_axis_tdata[3*WORD +: SAMPLE_W] = 16'h1234;
            ch_select = SEL_W'(sel);
            expw = s_axis_tdata[((sel < NUM_CH) ? sel : 0)*WORD +: WORD];
            @(negedge clock);
            chk("mon_data", mon_data, expw);
        end
        s_axis_tvalid = '0;

        run_capture(0, 2, 1'b0, 16'd0, 0, -1);
        run_capture(1, 4, 1'b1, 16'd100, 2, -1);
        run_capture(2, 5, 1'b0, 16'd0, 1, -1);
        run_capture(3, 1, 1'b1, 16'(int'($urandom_range(4000)) - 2000), 2, -1);
        run_capture(2, 0, 1'b0, 16'd0, 0, 10);
        run_capture(3, 3, 1'b1, 16'(int'($urandom_range(4000)) - 2000), 1, -1);

`ifdef RF_CAPTURE_TIMESTAMP_EN
        reset = 1'b1; s_axis_tvalid = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_capture(4, 0, 1'b0, 16'd0, 0, -1);
        chk("trig_timestamp", WORD'(trig_timestamp), WORD'(36));
`endif

        repeat (4) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_adc_capture.md
# rf_adc_capture

Parametrised ADC monitor and snapshot-capture block for the RF data converter control path. It accepts NUM_CH AXI-stream ADC channels and presents one selected channel as a registered live monitor word. On trigger, it records DEPTH consecutive valid beats of the selected channel into an on-chip buffer. It then streams the buffer out over an AXI-stream master port for software or an ILA to consume.

## Interface
- NUM_CH, 8, number of ADC channels (≥2)
- NUM_LINES, 8, samples per beat
- SAMPLE_W, 16, bits per sample (two's complement)
- DEPTH, 1024, capture beats (power of two, ≥4)
- SEL_W, $clog2(NUM_CH), channel-select width

- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- s_axis_tvalid  in  NUM_CH  per-channel valid
- s_axis_tdata  in  NUM_CH*NUM_LINES*SAMPLE_W  channel c at bits [(c+1)*NUM_LINES*SAMPLE_W-1 : c*NUM_LINES*SAMPLE_W]; line 0 in the LSBs
- s_axis_tready  out  NUM_CH  per-channel ready
- ch_select  in  SEL_W  live-monitor and capture channel
- mon_data  out  NUM_LINES*SAMPLE_W  registered selected-channel word
- arm  in  1  single-cycle arm request
- force_trig  in  1  manual trigger
- trig_en  in  1  enables the level trigger
- trig_level  in  SAMPLE_W  signed threshold
- capture_busy  out  1  high in ARMED or CAPTURE
- capture_done  out  1  sticky; buffer fully read out
- m_axis_tvalid  out  1  readout valid
- m_axis_tdata  out  NUM_LINES*SAMPLE_W  readout word
- m_axis_tlast  out  1  marks beat DEPTH-1
- m_axis_tready  in  1  readout ready

## Operation
- Inputs are never back-pressured. s_axis_tready is all-ones except during reset.
- mon_data <= selected channel tdata every cycle, independent of tvalid.
- ch_select values ≥ NUM_CH select channel 0.
- State machine:
  - IDLE: arm -> ARMED. Latch ch_select into cap_ch; clear capture_done.
  - ARMED: on a trigger beat -> CAPTURE, and store that beat at address 0.
    - A trigger beat is a cap_ch tvalid beat where force_trig=1, or where trig_en=1 and line 0 shows a rising crossing.
    - Rising crossing: signed(line0) > trig_level and the previous cap_ch valid beat's line0 ≤ trig_level.
    - The previous-sample register is cleared to the most-negative value on arm.
  - CAPTURE: every cap_ch tvalid beat is written at an incrementing address. The beat written at DEPTH-1 -> READOUT.
  - READOUT: stream addresses 0..DEPTH-1 in order. The handshake on beat DEPTH-1 -> IDLE and sets capture_done.
- arm is ignored outside IDLE. force_trig is ignored outside ARMED.
- ch_select changes after arm affect mon_data only, not the capture.
- The write address is log2(DEPTH) bits. It cannot wrap inside a capture, because the FSM leaves CAPTURE on address DEPTH-1.

## Timing
- Reset values:
  - s_axis_tready=0, mon_data=0, capture_busy=0, capture_done=0
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0
  - FSM=IDLE, all addresses=0
- Reset mid-operation abandons the capture or readout. Buffer contents are then undefined and not cleared.
- s_axis_tready rises the first cycle after reset deasserts.
- mon_data latency: 1 cycle.
- arm at cycle N: capture_busy=1 at N+1. A trigger beat is accepted from N+1.
- Buffer read uses a one-cycle registered RAM.
  - m_axis_tvalid first asserts 2 cycles after the final capture write.
  - Once a beat is presented, tdata, tlast and tvalid hold until accepted.
  - With tready held high, one beat transfers per cycle with no bubbles; read-ahead is required.
- capture_busy falls the cycle the FSM enters READOUT.
- capture_done rises the cycle after the tlast handshake and holds until the next accepted arm.

## Configuration
- RF_CAPTURE_TIMESTAMP_EN defined:
  - Adds a free-running 32-bit counter of cap_ch valid beats. It resets to 0 and wraps at 2^32-1 -> 0.
  - Adds output port trig_timestamp [31:0], loaded with the counter value on the trigger beat. Reset value 0.
- Undefined: the counter and port are absent. All other behaviour is identical.

## Test plan
- Reset, then ch_select=3, channel 3 tdata line0=0x1234 -> mon_data line0=0x1234 one cycle later; s_axis_tready=all-ones.
- arm with ch_select=2, force_trig on the first valid beat, DEPTH beats of ramp 0..DEPTH-1 on line0, m_axis_tready=1 -> DEPTH readout beats with line0=0..DEPTH-1 in order, no gaps, tlast only on the last; capture_done=1.
- trig_en=1, trig_level=100, line0 sequence 50,100,101 -> capture starts at the beat with 101; readout beat 0 line0=101.
- Readout with m_axis_tready toggling 1,0,0,1 -> tdata stable while stalled, no lost or duplicated beats, and arm pulses during readout are ignored.
- Assert reset during CAPTURE at beat 10 -> all outputs return to reset values, FSM=IDLE, and a new arm and capture completes correctly.
- With RF_CAPTURE_TIMESTAMP_EN, trigger on the 37th valid beat after reset -> trig_timestamp=36.
